// File: rtl/ds3502_wiper_ctrl_if.sv
// Bundle of set-point and register-writer signals for ds3502_wiper_ctrl.
//
// Handshakes:
//   set-point side: a set-point is taken on any clock edge where
//     set_valid && set_ready. set_ready stays high once initialisation is
//     done, so set_valid may be a single-cycle strobe. Values are not queued;
//     the latest accepted value replaces any earlier one.
//   writer side: wr_load is a one-cycle request. wr_addr/wr_data are stable
//     from the wr_load cycle until the writer has raised and then dropped
//     wr_busy. A request is only issued while wr_busy is low.
interface ds3502_wiper_ctrl_if;
  logic       set_valid;
  logic [7:0] set_wiper;
  logic       set_ready;
  logic [6:0] cur_wiper;
  logic       init_done;
  logic       err;
  logic       wr_load;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_busy;

  // System/writer side: drives set-points and writer busy.
  modport master (
    output set_valid, set_wiper, wr_busy,
    input  set_ready, cur_wiper, init_done, err, wr_load, wr_addr, wr_data
  );

  // Controller side.
  modport slave (
    input  set_valid, set_wiper, wr_busy,
    output set_ready, cur_wiper, init_done, err, wr_load, wr_addr, wr_data
  );
endinterface

// File: rtl/ds3502_wiper_ctrl.sv
// ds3502_wiper_ctrl: sequences DS3502 register writes through the I2C
// register writer. Writes CR then the initial wiper after reset, then turns
// set-points into wiper writes with timeout/retry and a sticky error flag.
// Optional feature macro: DS3502_RAMP_EN limits each wiper write to RAMP_STEP
// and spaces writes by RAMP_GAP idle cycles.
// dbg_state exposes the FSM state for checkers.
module ds3502_wiper_ctrl #(
  parameter logic [7:0]  CR_VALUE    = 8'h80,
  parameter logic [6:0]  INIT_WIPER  = 7'd64,
  parameter logic [15:0] TIMEOUT_CYC = 16'd64,
`ifdef DS3502_RAMP_EN
  parameter logic [6:0]  RAMP_STEP   = 7'd4,
  parameter logic [15:0] RAMP_GAP    = 16'd5000,
`endif
  parameter logic [1:0]  MAX_RETRY   = 2'd3
) (
  input  logic                 clk,
  input  logic                 rst,
  ds3502_wiper_ctrl_if.slave   bus,
  output logic [2:0]           dbg_state
);

  localparam logic [7:0] ADDR_WR = 8'h00;
  localparam logic [7:0] ADDR_CR = 8'h02;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_ISSUE = 3'd1,
    S_ACK   = 3'd2,
    S_DONE  = 3'd3,
    S_IDLE  = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  // Which write the FSM is currently working on.
  typedef enum logic [1:0] {
    PH_CR   = 2'd0,
    PH_INIT = 2'd1,
    PH_RUN  = 2'd2
  } phase_t;

  state_t      state;
  phase_t      phase;
  logic        wr_load_q;
  logic [7:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
  logic        init_done_q;
  logic        err_q;
  logic [6:0]  cur_wiper_q;
  logic [6:0]  target;
  logic [1:0]  retry;
  logic [15:0] timer;
  logic [6:0]  set_clamped;
  logic [6:0]  next_wiper;

  // Requested values above 127 saturate to full scale.
  assign set_clamped = bus.set_wiper[7] ? 7'd127 : bus.set_wiper[6:0];

`ifdef DS3502_RAMP_EN
  // Next wiper value: step toward target by at most RAMP_STEP, never past it.
  always_comb begin
    next_wiper = target;
    if (target > cur_wiper_q) begin
      if ((target - cur_wiper_q) > RAMP_STEP) next_wiper = cur_wiper_q + RAMP_STEP;
    end else if (target < cur_wiper_q) begin
      if ((cur_wiper_q - target) > RAMP_STEP) next_wiper = cur_wiper_q - RAMP_STEP;
    end
  end
`else
  // Without ramping the target is written in a single step.
  always_comb begin
    next_wiper = target;
  end
`endif

  // Main sequencer: boot writes, set-point writes, timeout/retry, error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_BOOT;
      phase       <= PH_CR;
      wr_load_q   <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      cur_wiper_q <= INIT_WIPER;
      target      <= INIT_WIPER;
      retry       <= 2'd0;
      timer       <= 16'd0;
    end else begin
      case (state)
        S_BOOT: begin
          if (!bus.wr_busy) begin
            wr_addr_q <= ADDR_CR;
            wr_data_q <= CR_VALUE;
            wr_load_q <= 1'b1;
            phase     <= PH_CR;
            state     <= S_ISSUE;
          end
        end

        // wr_load is high for exactly the cycle spent in this state.
        S_ISSUE: begin
          wr_load_q <= 1'b0;
          timer     <= 16'd0;
          state     <= S_ACK;
        end

        S_ACK: begin
          timer <= timer + 16'd1;
          if (bus.wr_busy) begin
            state <= S_DONE;
          end else if (timer == TIMEOUT_CYC) begin
            if (retry < MAX_RETRY) begin
              retry     <= retry + 2'd1;
              wr_load_q <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              // Give up on this write; the sequence carries on regardless.
              err_q  <= 1'b1;
              retry  <= 2'd0;
              target <= cur_wiper_q;
              case (phase)
                PH_CR: begin
                  wr_addr_q <= ADDR_WR;
                  wr_data_q <= {1'b0, INIT_WIPER};
                  wr_load_q <= 1'b1;
                  phase     <= PH_INIT;
                  state     <= S_ISSUE;
                end
                PH_INIT: begin
                  init_done_q <= 1'b1;
                  phase       <= PH_RUN;
                  state       <= S_IDLE;
                end
                default: state <= S_IDLE;
              endcase
            end
          end
        end

        S_DONE: begin
          if (!bus.wr_busy) begin
            retry <= 2'd0;
            if (wr_addr_q == ADDR_WR) cur_wiper_q <= wr_data_q[6:0];
            case (phase)
              PH_CR: begin
                wr_addr_q <= ADDR_WR;
                wr_data_q <= {1'b0, INIT_WIPER};
                wr_load_q <= 1'b1;
                phase     <= PH_INIT;
                state     <= S_ISSUE;
              end
              PH_INIT: begin
                init_done_q <= 1'b1;
                phase       <= PH_RUN;
                state       <= S_IDLE;
              end
              default: begin
`ifdef DS3502_RAMP_EN
                timer <= 16'd0;
                state <= S_GAP;
`else
                state <= S_IDLE;
`endif
              end
            endcase
          end
        end

        S_IDLE: begin
          if ((target != cur_wiper_q) && !bus.wr_busy) begin
            wr_addr_q <= ADDR_WR;
            wr_data_q <= {1'b0, next_wiper};
            wr_load_q <= 1'b1;
            state     <= S_ISSUE;
          end
        end

`ifdef DS3502_RAMP_EN
        // Hold off between ramp steps.
        S_GAP: begin
          if (timer >= RAMP_GAP - 16'd1) begin
            state <= S_IDLE;
          end else begin
            timer <= timer + 16'd1;
          end
        end
`endif

        default: state <= S_BOOT;
      endcase

      // Accepted set-points override anything above, including a dropped write.
      if (bus.set_valid && init_done_q) target <= set_clamped;
    end
  end

  assign bus.set_ready = init_done_q;
  assign bus.cur_wiper = cur_wiper_q;
  assign bus.init_done = init_done_q;
  assign bus.err       = err_q;
  assign bus.wr_load   = wr_load_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_ds3502_wiper_ctrl.sv
// Self-checking bench for ds3502_wiper_ctrl: writer model with configurable
// busy response, scoreboard of expected {addr,data} writes.
module tb_ds3502_wiper_ctrl;

  localparam int TIMEOUT  = 64;
  localparam int RAMP_GAP = 5000;
  localparam logic [2:0] ST_BOOT = 3'd0;
  localparam logic [2:0] ST_IDLE = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;
  int         cyc = 0;

  ds3502_wiper_ctrl_if bif ();

  ds3502_wiper_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif),
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [15:0] exp_q[$];
  int          load_cyc[$];
  int          load_cnt = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          writer_on = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // writer model and load monitor
  initial begin
    logic [15:0] e;
    bif.wr_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bif.wr_load) begin
        load_cnt++;
        load_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_load", {bif.wr_addr, bif.wr_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("load", {16'd0, bif.wr_addr, bif.wr_data}, {16'd0, e});
        end
        if (writer_on) begin
          @(posedge clk);
          #1 bif.wr_busy = 1'b1;
          repeat (3) @(posedge clk);
          #1 bif.wr_busy = 1'b0;
        end
      end
    end
  end

  // driver tasks
  task automatic set_point(input logic [7:0] v);
    @(negedge clk);
    bif.set_valid = 1'b1;
    bif.set_wiper = v;
    @(negedge clk);
    bif.set_valid = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int i = 0;
    while (i < 400 && !bif.init_done) begin
      @(negedge clk);
      i++;
    end
    check(tag, {31'd0, bif.init_done}, 32'd1);
  endtask

  task automatic wait_cur(input logic [6:0] v, input int bound, input string tag);
    int i = 0;
    while (i < bound && !(bif.cur_wiper == v && dbg_state == ST_IDLE && exp_q.size() == 0)) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_bound"}, {31'd0, (i < bound)}, 32'd1);
    check(tag, {25'd0, bif.cur_wiper}, {25'd0, v});
  endtask

  task automatic wait_busy(input string tag);
    int i = 0;
    while (i < 200 && !bif.wr_busy) begin
      @(negedge clk);
      i++;
    end
    check(tag, {31'd0, bif.wr_busy}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_load",  {31'd0, bif.wr_load},   32'd0);
    check("rst_init",  {31'd0, bif.init_done}, 32'd0);
    check("rst_ready", {31'd0, bif.set_ready}, 32'd0);
    check("rst_err",   {31'd0, bif.err},       32'd0);
    check("rst_cur",   {25'd0, bif.cur_wiper}, 32'd64);
    check("rst_addr",  {24'd0, bif.wr_addr},   32'd0);
    check("rst_state", {29'd0, dbg_state},     {29'd0, ST_BOOT});
    exp_q.push_back(16'h0280);
    exp_q.push_back(16'h0040);
    rst = 1'b1;
    wait_init("init_done");
    check("init_q_empty", exp_q.size(), 32'd0);
    check("init_cur",     {25'd0, bif.cur_wiper}, 32'd64);
    check("init_ready",   {31'd0, bif.set_ready}, 32'd1);
  endtask

  // main sequence
  initial begin
    int saved;
    int gap;
    rst           = 1'b0;
    bif.set_valid = 1'b0;
    bif.set_wiper = 8'd0;
    do_reset();

`ifdef DS3502_RAMP_EN
    load_cyc.delete();
    exp_q.push_back(16'h003C);
    exp_q.push_back(16'h0038);
    exp_q.push_back(16'h0034);
    exp_q.push_back(16'h0032);
    set_point(8'd50);
    wait_cur(7'd50, 4 * RAMP_GAP + 500, "ramp_cur");
    check("ramp_loads", load_cyc.size(), 32'd4);
    for (int i = 1; i < load_cyc.size(); i++) begin
      gap = load_cyc[i] - load_cyc[i-1];
      check("ramp_gap", {31'd0, (gap >= RAMP_GAP)}, 32'd1);
    end
`else
    // simple set-point
    exp_q.push_back(16'h0064);
    set_point(8'd100);
    wait_cur(7'd100, 200, "set100_cur");

    // clamp, then equal set-point produces no write
    exp_q.push_back(16'h007F);
    set_point(8'hFF);
    wait_cur(7'd127, 200, "clamp_cur");
    saved = load_cnt;
    set_point(8'd127);
    repeat (50) @(negedge clk);
    check("same_no_load", load_cnt, saved);

    // two set-points during one write: last one wins, single follow-up write
    exp_q.push_back(16'h001E);
    set_point(8'd30);
    wait_busy("busy_30");
    set_point(8'd10);
    set_point(8'd20);
    exp_q.push_back(16'h0014);
    wait_cur(7'd20, 300, "last_wins_cur");
    saved = load_cnt;
    repeat (50) @(negedge clk);
    check("last_wins_no_extra", load_cnt, saved);

    // writer never responds: 4 attempts, then sticky err
    check("err_before", {31'd0, bif.err}, 32'd0);
    writer_on = 1'b0;
    load_cyc.delete();
    repeat (4) exp_q.push_back(16'h005A);
    set_point(8'd90);
    begin
      int i = 0;
      while (i < 6 * TIMEOUT + 100 && !bif.err) begin
        @(negedge clk);
        i++;
      end
    end
    check("err_set", {31'd0, bif.err}, 32'd1);
    repeat (4) @(negedge clk);
    check("err_state_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("err_cur_kept",   {25'd0, bif.cur_wiper}, 32'd20);
    check("retry_loads",    load_cyc.size(), 32'd4);
    for (int i = 1; i < load_cyc.size(); i++) begin
      gap = load_cyc[i] - load_cyc[i-1];
      check("retry_gap", {31'd0, (gap >= TIMEOUT && gap <= TIMEOUT + 4)}, 32'd1);
    end
    saved = load_cnt;
    repeat (2 * TIMEOUT) @(negedge clk);
    check("no_load_after_err", load_cnt, saved);

    // err stays set across a later good write
    writer_on = 1'b1;
    exp_q.push_back(16'h0028);
    set_point(8'd40);
    wait_cur(7'd40, 200, "after_err_cur");
    check("err_sticky", {31'd0, bif.err}, 32'd1);

    // reset in the middle of a write restarts the init sequence
    exp_q.push_back(16'h0046);
    set_point(8'd70);
    wait_busy("busy_70");
    do_reset();
    check("reset_err_cleared", {31'd0, bif.err}, 32'd0);
`endif

    repeat (20) @(negedge clk);
    check("final_q_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
